// File: rtl/ram_ctrl.sv
// Byte-addressable single-port RAM with a valid/ready request channel and a registered response.
// Define RAM_MISALIGN_EN to split misaligned accesses over two cycles; otherwise they are rejected with rsp_err.
module ram_ctrl #(
    parameter int  ADDR_W     = 8,
    parameter int  WORD_BYTES = 2,
    localparam int DATA_W     = 8 * WORD_BYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [WORD_BYTES-1:0] req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int OFF_W  = $clog2(WORD_BYTES);
    localparam int WIDX_W = ADDR_W - OFF_W;
    localparam int NWORDS = 2 ** WIDX_W;

`ifdef RAM_MISALIGN_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    typedef enum logic {IDLE, SECOND} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DATA_W-1:0]       r_mem [NWORDS];

    logic [ADDR_W-1:0]       r_addr;
    logic                    r_we;
    logic [WORD_BYTES-1:0]   r_be;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W-1:0]       r_partial;

    logic                    w_accept;
    logic                    w_second;
    logic [ADDR_W-1:0]       w_addr;
    logic                    w_we;
    logic [WORD_BYTES-1:0]   w_be;
    logic [DATA_W-1:0]       w_wdata;
    logic [OFF_W-1:0]        w_off;
    logic                    w_misaligned;
    logic [WIDX_W-1:0]       w_word;
    logic                    w_mem_en;
    logic [DATA_W-1:0]       w_rd_word;
    logic [WORD_BYTES-1:0]   w_byte_we;
    logic [DATA_W-1:0]       w_byte_wd;
    logic [DATA_W-1:0]       w_rdata_next;

    assign req_ready    = (r_state == IDLE);
    assign w_accept     = req_valid && req_ready;
    assign w_second     = (r_state == SECOND);

    // In SECOND the latched request drives the datapath and the next word is addressed.
    assign w_addr       = w_second ? r_addr  : req_addr;
    assign w_we         = w_second ? r_we    : req_we;
    assign w_be         = w_second ? r_be    : req_be;
    assign w_wdata      = w_second ? r_wdata : req_wdata;
    assign w_off        = w_addr[OFF_W-1:0];
    assign w_misaligned = (w_off != '0);
    assign w_word       = w_second ? (r_addr[ADDR_W-1:OFF_W] + WIDX_W'(1)) : req_addr[ADDR_W-1:OFF_W];
    assign w_mem_en     = w_second || (w_accept && (!w_misaligned || MISALIGN_EN));
    assign w_rd_word    = r_mem[w_word];

    for (genvar k = 0; k < WORD_BYTES; k++) begin : g_lane
        localparam logic [OFF_W-1:0] LANE = OFF_W'(k);
        logic [OFF_W-1:0] w_src;
        logic [OFF_W-1:0] w_rd_lane;
        logic             w_wr_on;
        logic             w_rd_on;

        // Memory lane LANE is written from request byte w_src; request byte LANE reads memory lane w_rd_lane.
        // A lane below the offset belongs to the following word, i.e. to the second half.
        assign w_src     = LANE - w_off;
        assign w_rd_lane = LANE + w_off;
        assign w_wr_on   = w_second ? (LANE < w_off) : (LANE >= w_off);
        assign w_rd_on   = w_second ? (w_rd_lane < w_off) : (w_rd_lane >= w_off);

        assign w_byte_we[k]        = w_mem_en && w_we && w_be[w_src] && w_wr_on;
        assign w_byte_wd[8*k +: 8] = w_wdata[{w_src, 3'b000} +: 8];
        assign w_rdata_next[8*k +: 8] = w_rd_on  ? w_rd_word[{w_rd_lane, 3'b000} +: 8] :
                                        w_second ? r_partial[8*k +: 8] : 8'h00;
    end

    // NOTE: the storage array has no reset; clearing it would turn the RAM into thousands of flops.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (w_byte_we[k]) begin
                r_mem[w_word][8*k +: 8] <= w_byte_wd[8*k +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: next state gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_misaligned && MISALIGN_EN) w_state_next = SECOND;
            SECOND:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_partial <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (w_second) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= r_we ? '0 : w_rdata_next;
                rsp_err   <= 1'b0;
            end else if (w_accept) begin
                if (w_misaligned && MISALIGN_EN) begin
                    r_addr    <= req_addr;
                    r_we      <= req_we;
                    r_be      <= req_be;
                    r_wdata   <= req_wdata;
                    r_partial <= w_rdata_next;
                end else begin
                    // Without the split path a misaligned request is answered with an error and no data.
                    rsp_valid <= 1'b1;
                    rsp_err   <= w_misaligned;
                    rsp_rdata <= (req_we || w_misaligned) ? '0 : w_rdata_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: a byte-array model predicts each response, a negedge monitor compares.
// Works with or without RAM_MISALIGN_EN defined.
module tb_ram_ctrl;

    localparam int AW = 8;
    localparam int WB = 2;

`ifdef RAM_MISALIGN_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    ram_ctrl #(.ADDR_W(AW), .WORD_BYTES(WB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] ref_mem [256];
    int         checks = 0;
    int         errors = 0;
    int         ncyc   = 0;
    logic       exp_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the request touches bytes (addr+i) mod 256 for i in 0..WB-1.
    task automatic model(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                         input logic [1:0] be, output logic [15:0] rd, output logic err, output int lat);
        int off;
        off = int'(addr) % WB;
        rd  = '0;
        err = 1'b0;
        lat = 1;
        if (off != 0 && !EN) begin
            err = 1'b1;
            return;
        end
        if (off != 0) lat = 2;
        for (int i = 0; i < WB; i++) begin
            int a;
            a = (int'(addr) + i) % 256;
            if (we) begin
                if (be[i]) ref_mem[a] = wd[8*i +: 8];
            end else begin
                rd[8*i +: 8] = ref_mem[a];
            end
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_latency", ncyc, e.due);
            end
        end
    end

    task automatic do_req(input logic we, input logic [7:0] addr, input logic [15:0] wd, input logic [1:0] be);
        logic [15:0] rd;
        logic        err;
        int          lat;
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(!exp_busy));
        if (exp_busy) begin
            req_valid = 1'b0;
            @(negedge clk);
            check("req_ready_after_second", 32'(req_ready), 32'd1);
            exp_busy = 1'b0;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        @(posedge clk);
        model(we, addr, wd, be, rd, err, lat);
        sb.push_back('{rdata: rd, err: err, due: ncyc + lat});
        exp_busy = (lat == 2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_busy) begin
                check("req_ready_second", 32'(req_ready), 32'd0);
                exp_busy = 1'b0;
            end
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        idle(4);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;

        for (int w = 0; w < 256 / WB; w++) do_req(1'b1, 8'(w * WB), 16'($urandom), 2'b11);
        drain();

        do_req(1'b1, 8'h10, 16'hBEEF, 2'b11);
        do_req(1'b0, 8'h10, 16'h0000, 2'b00);
        do_req(1'b1, 8'h10, 16'h1234, 2'b10);
        do_req(1'b0, 8'h10, 16'h0000, 2'b00);
        do_req(1'b1, 8'h11, 16'hA55A, 2'b11);
        do_req(1'b0, 8'h10, 16'h0000, 2'b00);
        do_req(1'b0, 8'h12, 16'h0000, 2'b00);
        do_req(1'b1, 8'hFE, 16'h3C4B, 2'b11);
        do_req(1'b1, 8'h00, 16'h0077, 2'b11);
        do_req(1'b0, 8'hFF, 16'h0000, 2'b00);
        do_req(1'b1, 8'h30, 16'hFFFF, 2'b00);
        do_req(1'b0, 8'h30, 16'h0000, 2'b00);
        do_req(1'b0, 8'h00, 16'h0000, 2'b00);
        do_req(1'b0, 8'h02, 16'h0000, 2'b00);
        do_req(1'b0, 8'h04, 16'h0000, 2'b00);
        drain();

        // Reset while idle with a non-zero response held: registered outputs return to zero.
        do_req(1'b0, 8'h10, 16'h0000, 2'b00);
        drain();
        rst_n = 1'b0;
        #1;
        check("idle_reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("idle_reset_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

`ifdef RAM_MISALIGN_EN
        // Reset during SECOND: first byte committed, second dropped, no response.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h21;
        req_wdata = 16'hCAFE;
        req_be    = 2'b11;
        @(posedge clk);
        ref_mem[8'h21] = 8'hFE;
        @(negedge clk);
        check("second_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        idle(3);
        do_req(1'b0, 8'h20, 16'h0000, 2'b00);
        do_req(1'b0, 8'h22, 16'h0000, 2'b00);
        drain();
`endif

        for (int n = 0; n < 300; n++) begin
            do_req(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), 2'($urandom));
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
